// File: rtl/cordic_pkg.sv
// Shared constants, result-ID encodings and sweep FSM state type for the cordic issue controller.
package cordic_pkg;

    localparam int BW = 32;
    localparam int AW = 32;

    // 1/K * 2^31 seed so the core output lands at full scale without a post-multiply.
    localparam logic [BW-1:0] XIN_INIT = 32'h4DBA76D4;

    localparam logic [1:0] ID_REQ0  = 2'd0;
    localparam logic [1:0] ID_REQ1  = 2'd1;
    localparam logic [1:0] ID_SWEEP = 2'd2;

    typedef enum logic [1:0] {
        SWEEP_IDLE  = 2'd0,
        SWEEP_RUN   = 2'd1,
        SWEEP_DRAIN = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/cordic_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, pointer steps past the winner after every grant.
module cordic_rr_arb
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // ptr_q == 0 favours requester 0 on contention, 1 favours requester 1.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        if (valid[0] && (!valid[1] || !ptr_q)) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cordic_issue_ctrl.sv
// Shares one pipelined cordic core between two requesters, tags in-flight samples, returns results.
// Optional angle sweep generator enabled by defining CORDIC_SWEEP_EN.
module cordic_issue_ctrl
    import cordic_pkg::*;
#(
    parameter int CORE_LAT = 17,
    parameter int SWEEP_N  = 360
)
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_angle,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_angle,
    output logic          req1_ready,
    output logic [BW-1:0] core_xin,
    output logic [BW-1:0] core_yin,
    output logic [AW-1:0] core_angle,
    input  logic [BW-1:0] core_xout,
    input  logic [BW-1:0] core_yout,
    output logic          res_valid,
    output logic [1:0]    res_id,
    output logic [BW-1:0] res_cos,
    output logic [BW-1:0] res_sin,
`ifdef CORDIC_SWEEP_EN
    input  logic          sweep_start,
    output logic          sweep_done,
    output sweep_state_e  sweep_state,
`endif
    output logic          busy
);

    // Handshake: a request transfers on the rising edge where reqN_valid && reqN_ready.
    // Ready is a combinational grant and is never raised without the matching valid.
    logic [1:0] grant;

    cordic_rr_arb u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .valid   ({req1_valid, req0_valid}),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign core_xin   = XIN_INIT;
    assign core_yin   = '0;

    logic          issue;
    logic [1:0]    issue_id;
    logic [AW-1:0] core_angle_q, core_angle_d;

    // Stage k holds the tag of the sample issued k edges ago; the last stage lines up with core_xout.
    logic [CORE_LAT:0] dl_valid_q, dl_valid_d;
    logic [1:0]        dl_id_q [CORE_LAT+1];
    logic [1:0]        dl_id_d [CORE_LAT+1];

    logic          res_valid_q, res_valid_d;
    logic [1:0]    res_id_q, res_id_d;
    logic [BW-1:0] res_cos_q, res_cos_d;
    logic [BW-1:0] res_sin_q, res_sin_d;

`ifdef CORDIC_SWEEP_EN
    localparam logic [63:0] TWO32  = 64'h1_0000_0000;
    localparam logic [31:0] STEP_Q = 32'(TWO32 / 64'(SWEEP_N));
    localparam logic [31:0] STEP_R = 32'(TWO32 % 64'(SWEEP_N));
    localparam logic [31:0] LAST_I = 32'(SWEEP_N - 1);

    sweep_state_e      state_q, state_d;
    logic [31:0]       idx_q, idx_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [31:0]       rem_q, rem_d;
    logic              sweep_issue;
    logic              last_out;
    logic              sweep_done_q, sweep_done_d;
    logic [CORE_LAT:0] dl_last_q, dl_last_d;

    // acc_q tracks floor(i*2^32/N) exactly; rem_q carries the fractional part scaled by N.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        sweep_issue = 1'b0;
        last_out    = dl_valid_q[CORE_LAT] && dl_last_q[CORE_LAT];
        case (state_q)
            SWEEP_IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP_RUN;
                    idx_d   = '0;
                    acc_d   = '0;
                    rem_d   = '0;
                end
            end
            SWEEP_RUN: begin
                if (!req0_valid && !req1_valid) begin
                    sweep_issue = 1'b1;
                    idx_d       = idx_q + 32'd1;
                    if (rem_q + STEP_R >= 32'(SWEEP_N)) begin
                        rem_d = rem_q + STEP_R - 32'(SWEEP_N);
                        acc_d = acc_q + STEP_Q + 32'd1;
                    end else begin
                        rem_d = rem_q + STEP_R;
                        acc_d = acc_q + STEP_Q;
                    end
                    if (idx_q == LAST_I) begin
                        state_d = SWEEP_DRAIN;
                    end
                end
            end
            SWEEP_DRAIN: begin
                if (last_out) begin
                    state_d = SWEEP_IDLE;
                end
            end
            default: state_d = SWEEP_IDLE;
        endcase
        dl_last_d    = {dl_last_q[CORE_LAT-1:0], sweep_issue && (idx_q == LAST_I)};
        sweep_done_d = last_out;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SWEEP_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            dl_last_q    <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            dl_last_q    <= dl_last_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign sweep_done  = sweep_done_q;
    assign sweep_state = state_q;
`endif

    // Requesters always beat the sweep; the arbiter already resolves req0 against req1.
    always_comb begin
        issue        = 1'b0;
        issue_id     = ID_REQ0;
        core_angle_d = core_angle_q;
        if (grant[0]) begin
            issue        = 1'b1;
            issue_id     = ID_REQ0;
            core_angle_d = req0_angle;
        end else if (grant[1]) begin
            issue        = 1'b1;
            issue_id     = ID_REQ1;
            core_angle_d = req1_angle;
        end
`ifdef CORDIC_SWEEP_EN
        else if (sweep_issue) begin
            issue        = 1'b1;
            issue_id     = ID_SWEEP;
            core_angle_d = acc_q;
        end
`endif
    end

    always_comb begin
        dl_valid_d = {dl_valid_q[CORE_LAT-1:0], issue};
        dl_id_d[0] = issue_id;
        for (int k = 1; k <= CORE_LAT; k++) begin
            dl_id_d[k] = dl_id_q[k-1];
        end
        res_valid_d = dl_valid_q[CORE_LAT];
        res_id_d    = res_id_q;
        res_cos_d   = res_cos_q;
        res_sin_d   = res_sin_q;
        if (dl_valid_q[CORE_LAT]) begin
            res_id_d  = dl_id_q[CORE_LAT];
            res_cos_d = core_xout;
            res_sin_d = core_yout;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_angle_q <= '0;
            dl_valid_q   <= '0;
            for (int k = 0; k <= CORE_LAT; k++) begin
                dl_id_q[k] <= '0;
            end
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_cos_q    <= '0;
            res_sin_q    <= '0;
        end else begin
            core_angle_q <= core_angle_d;
            dl_valid_q   <= dl_valid_d;
            for (int k = 0; k <= CORE_LAT; k++) begin
                dl_id_q[k] <= dl_id_d[k];
            end
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_cos_q    <= res_cos_d;
            res_sin_q    <= res_sin_d;
        end
    end

    assign core_angle = core_angle_q;
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_cos    = res_cos_q;
    assign res_sin    = res_sin_q;
    assign busy       = |dl_valid_q;

endmodule

// File: tb/tb_cordic_issue_ctrl.sv
// Bench for cordic_issue_ctrl: ideal trig core model, scoreboard queue, arbitration table, corner sequences.
module tb_cordic_issue_ctrl;
    import cordic_pkg::*;

    localparam int CORE_LAT = 17;
    localparam int SWEEP_N  = 360;
    localparam int EW       = 66;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0]   req0_angle = '0, req1_angle = '0;
    logic          req0_ready, req1_ready;
    logic [BW-1:0] core_xin, core_yin, core_xout, core_yout;
    logic [31:0]   core_angle;
    logic          res_valid, busy;
    logic [1:0]    res_id;
    logic [BW-1:0] res_cos, res_sin;
`ifdef CORDIC_SWEEP_EN
    logic          sweep_start = 1'b0;
    logic          sweep_done;
    sweep_state_e  sweep_state;
    bit            sw_arm = 1'b0;
    int            sw_i = 0;
    int            sw_res = 0;
    int            done_cnt = 0;
`endif

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];

    cordic_issue_ctrl #(.CORE_LAT(CORE_LAT), .SWEEP_N(SWEEP_N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_angle  (req0_angle),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_angle  (req1_angle),
        .req1_ready  (req1_ready),
        .core_xin    (core_xin),
        .core_yin    (core_yin),
        .core_angle  (core_angle),
        .core_xout   (core_xout),
        .core_yout   (core_yout),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_cos     (res_cos),
        .res_sin     (res_sin),
`ifdef CORDIC_SWEEP_EN
        .sweep_start (sweep_start),
        .sweep_done  (sweep_done),
        .sweep_state (sweep_state),
`endif
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- ideal core model ----------------
    function automatic logic [31:0] trig_q31(input logic [31:0] a, input bit want_sin);
        real ph, v;
        ph = 6.283185307179586 * real'(a) / 4294967296.0;
        v  = want_sin ? $sin(ph) : $cos(ph);
        v  = v * 2147483647.0;
        return 32'($rtoi(v + ((v < 0.0) ? -0.5 : 0.5)));
    endfunction

    logic [31:0] px [CORE_LAT];
    logic [31:0] py [CORE_LAT];
    always @(posedge clock) begin
        px[0] <= trig_q31(core_angle, 1'b0);
        py[0] <= trig_q31(core_angle, 1'b1);
        for (int k = 1; k < CORE_LAT; k++) begin
            px[k] <= px[k-1];
            py[k] <= py[k-1];
        end
    end
    assign core_xout = px[CORE_LAT-1];
    assign core_yout = py[CORE_LAT-1];

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] mk_exp(input logic [1:0] id, input logic [31:0] a);
        return {id, trig_q31(a, 1'b0), trig_q31(a, 1'b1)};
    endfunction

    // Scoreboard: push on every accepted issue, pop on every result beat.
    always @(negedge clock) begin
        logic [EW-1:0] e;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (req0_valid && req0_ready) exp_q.push_back(mk_exp(ID_REQ0, req0_angle));
            if (req1_valid && req1_ready) exp_q.push_back(mk_exp(ID_REQ1, req1_angle));
`ifdef CORDIC_SWEEP_EN
            if (sw_arm && sw_i < SWEEP_N && !req0_valid && !req1_valid) begin
                logic [63:0] t;
                t = (64'(sw_i) << 32) / 64'(SWEEP_N);
                exp_q.push_back(mk_exp(ID_SWEEP, t[31:0]));
                sw_i++;
            end
`endif
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got beat id=%0d, want no beat", res_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_id", 64'(res_id), 64'(e[65:64]));
                    chk("sb_cos", 64'(res_cos), 64'(e[63:32]));
                    chk("sb_sin", 64'(res_sin), 64'(e[31:0]));
`ifdef CORDIC_SWEEP_EN
                    if (e[65:64] == ID_SWEEP) sw_res++;
`endif
                end
            end
`ifdef CORDIC_SWEEP_EN
            if (sweep_done) begin
                done_cnt++;
                chk("sweep_done_pos", 64'(sw_res), 64'(SWEEP_N));
            end
`endif
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk({"drain_", tag}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- arbitration vector table ----------------
    typedef struct {
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } arb_vec_t;

    arb_vec_t tbl [12];

    initial begin
        int n;
        int beats;
        logic [31:0] d;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_res_cos", 64'(res_cos), 64'd0);
        chk("rst_res_sin", 64'(res_sin), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_core_angle", 64'(core_angle), 64'd0);
        chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        chk("core_xin", 64'(core_xin), 64'h4DBA76D4);
        chk("core_yin", 64'(core_yin), 64'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        beats = 0;
        repeat (2 * CORE_LAT) begin
            @(posedge clock);
            #1 if (res_valid) beats++;
        end
        chk("rst_quiet_beats", 64'(beats), 64'd0);

        // Single issue: latency and near-full-scale result
        req0_valid = 1'b1;
        req0_angle = 32'h0;
        @(posedge clock);
        #1 req0_valid = 1'b0;
        chk("single_busy", 64'(busy), 64'd1);
        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        chk("single_latency", 64'(n), 64'(CORE_LAT + 1));
        chk("single_id", 64'(res_id), 64'(ID_REQ0));
        d = 32'h7FFFFFFF - res_cos;
        chk("single_cos_near_max", 64'(d <= 32'd16), 64'd1);
        d = res_sin[31] ? (~res_sin + 32'd1) : res_sin;
        chk("single_sin_near_zero", 64'(d <= 32'd16), 64'd1);
        drain("single");

        // Arbitration table from a known pointer
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            req0_angle = $urandom;
            req1_angle = $urandom;
            @(negedge clock);
            chk($sformatf("arb_r0_%0d", i), 64'(req0_ready), 64'(tbl[i].r0));
            chk($sformatf("arb_r1_%0d", i), 64'(req1_ready), 64'(tbl[i].r1));
            @(posedge clock);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("table");

        // Contention: fixed angles, strict alternation, 8 back-to-back beats
        apply_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_angle = 32'h40000000;
        req1_angle = 32'h80000000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk($sformatf("cont_r0_%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
            chk($sformatf("cont_r1_%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
            @(posedge clock);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        beats = 0;
        while (res_valid && beats < 20) begin
            if (beats == 0) chk("cont_sin_id0", 64'(res_sin), 64'h7FFFFFFF);
            if (beats == 1) chk("cont_cos_id1", 64'(res_cos), 64'h80000001);
            beats++;
            @(posedge clock);
            #1;
        end
        chk("cont_beats", 64'(beats), 64'd8);
        drain("cont");

        // Reset mid-flight: outstanding samples must vanish
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_angle = $urandom;
            @(posedge clock);
            #1;
        end
        req0_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("mid_busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_busy_now", 64'(busy), 64'd0);
        chk("mid_core_angle", 64'(core_angle), 64'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        beats = 0;
        repeat (2 * CORE_LAT + 4) begin
            @(posedge clock);
            #1 if (res_valid) beats++;
        end
        chk("mid_beats_after", 64'(beats), 64'd0);

`ifdef CORDIC_SWEEP_EN
        // Sweep with a 3-cycle req1 interruption
        sweep_start = 1'b1;
        @(posedge clock);
        #1 sweep_start = 1'b0;
        sw_arm = 1'b1;
        repeat (100) @(posedge clock);
        #1;
        req1_valid = 1'b1;
        req1_angle = $urandom;
        repeat (3) @(posedge clock);
        #1 req1_valid = 1'b0;
        n = 0;
        while ((sw_i < SWEEP_N || exp_q.size() != 0) && n < 2000) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("sweep_issued", 64'(sw_i), 64'(SWEEP_N));
        chk("sweep_results", 64'(sw_res), 64'(SWEEP_N));
        chk("sweep_done_cnt", 64'(done_cnt), 64'd1);
        chk("sweep_idle", 64'(sweep_state), 64'(SWEEP_IDLE));
`endif

        drain("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
